mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arb_pkg.sv | 27 ++
 rtl/mult_arbiter_if.sv | 34 +++
 rtl/mult_arbiter_rr.sv | 32 +++
 rtl/mult_arbiter.sv | 129 ++++++++++++
 tb/tb_mult_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// Shared definitions for the two-port matrix-multiply arbiter.
//   state_t     : controller states (IDLE, RUN, WAIT, DONE, ERR)
//   MAT_W       : operand matrix width (4x4 elements of 4 bits)
//   RES_W       : result width (16 elements of ELEM_W bits)
//   ELEM_W      : width of one result element
//   TIMEOUT_DEF : default number of WAIT cycles before a job is aborted
package mult_arb_pkg;

  localparam int MAT_W       = 64;
  localparam int RES_W       = 160;
  localparam int ELEM_W      = 10;
  localparam int TIMEOUT_DEF = 12;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT,
    DONE,
    ERR
  } state_t;

  // One-hot completion vector for the port that owns the current job.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side bus of the matrix-multiply arbiter.
//   req0/req1              : job requests, held until the matching done
//   mat_A0/mat_B0/A1/B1    : operand matrices per requester
//   done0/done1            : one-cycle completion pulses
//   err                    : one-cycle timeout flag, coincident with done
//   result                 : last successfully captured product
//   busy                   : arbiter is not idle
// master = requester side, slave = arbiter side.
interface mult_arbiter_if;
  import mult_arb_pkg::*;

  logic             req0;
  logic             req1;
  logic [MAT_W-1:0] mat_A0;
  logic [MAT_W-1:0] mat_B0;
  logic [MAT_W-1:0] mat_A1;
  logic [MAT_W-1:0] mat_B1;
  logic             done0;
  logic             done1;
  logic             err;
  logic             busy;
  logic [RES_W-1:0] result;

  modport master (
    output req0, req1, mat_A0, mat_B0, mat_A1, mat_B1,
    input  done0, done1, err, busy, result
  );

  modport slave (
    input  req0, req1, mat_A0, mat_B0, mat_A1, mat_B1,
    output done0, done1, err, busy, result
  );

endinterface

// File: rtl/mult_arbiter_rr.sv
// Two-port round-robin pick.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : pending requests
//   advance    : the current grant is being taken this cycle
//   gnt[1:0]   : one-hot grant (combinational), zero when no request
// After reset port 0 wins a tie; after each taken grant the other port
// becomes favoured.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio_reg;  // port favoured on a tie

  always_comb begin
    gnt = req;
    if (&req) gnt = prio_reg ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg <= 1'b0;
    end else if (advance && (|gnt)) begin
      // Served port 0 -> favour 1, served port 1 -> favour 0.
      prio_reg <= ~gnt[1];
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates two requesters onto a single external matrix-multiply path.
//   clk, rst_n           : clock, asynchronous active-low reset
//   bus (slave)          : requester bus, see mult_arbiter_if
//   path_mat_A/B         : operands latched at the grant, held for the job
//   path_mult_en         : one-cycle start strobe (RUN state)
//   path_rst             : synchronous clear of the path, high outside RUN/WAIT
//   path_mat_out         : product from the path
//   path_finish          : path finished, sticky until path_rst
// Job flow: IDLE -> RUN (1 cycle) -> WAIT (until finish or TIMEOUT cycles)
// -> DONE or ERR (1 cycle) -> IDLE. All outputs are registered.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_arbiter_if.slave    bus,
  output logic [MAT_W-1:0] path_mat_A,
  output logic [MAT_W-1:0] path_mat_B,
  output logic             path_mult_en,
  output logic             path_rst,
  input  logic [RES_W-1:0] path_mat_out,
  input  logic             path_finish
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter value in the last permitted WAIT cycle (counter starts at 0).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_reg;
  logic             owner_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       done_reg;
  logic             err_reg;
  logic             busy_reg;
  logic             mult_en_reg;
  logic             path_rst_reg;
  logic [MAT_W-1:0] mat_a_reg;
  logic [MAT_W-1:0] mat_b_reg;
  logic [RES_W-1:0] result_reg;

  logic [1:0] req_vec;
  logic [1:0] gnt;
  logic       advance;

  assign req_vec = {bus.req1, bus.req0};
  assign advance = (state_reg == IDLE);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_vec),
    .advance (advance),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= 1'b0;
      cnt_reg      <= '0;
      done_reg     <= 2'b00;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      mult_en_reg  <= 1'b0;
      path_rst_reg <= 1'b1;
      mat_a_reg    <= '0;
      mat_b_reg    <= '0;
      result_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|gnt) begin
            owner_reg    <= gnt[1];
            mat_a_reg    <= gnt[1] ? bus.mat_A1 : bus.mat_A0;
            mat_b_reg    <= gnt[1] ? bus.mat_B1 : bus.mat_B0;
            mult_en_reg  <= 1'b1;
            path_rst_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          mult_en_reg <= 1'b0;
          cnt_reg     <= '0;
          state_reg   <= WAIT;
        end
        WAIT: begin
          // A finish in the last permitted cycle still counts as success.
          if (path_finish) begin
            result_reg   <= path_mat_out;
            done_reg     <= port_onehot(owner_reg);
            path_rst_reg <= 1'b1;
            state_reg    <= DONE;
          end else if (cnt_reg == CNT_LAST) begin
            done_reg     <= port_onehot(owner_reg);
            err_reg      <= 1'b1;
            path_rst_reg <= 1'b1;
            state_reg    <= ERR;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE, ERR: begin
          done_reg     <= 2'b00;
          err_reg      <= 1'b0;
          busy_reg     <= 1'b0;
          path_rst_reg <= 1'b1;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.done0    = done_reg[0];
  assign bus.done1    = done_reg[1];
  assign bus.err      = err_reg;
  assign bus.busy     = busy_reg;
  assign bus.result   = result_reg;
  assign path_mat_A   = mat_a_reg;
  assign path_mat_B   = mat_b_reg;
  assign path_mult_en = mult_en_reg;
  assign path_rst     = path_rst_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction model.
module tb_mult_arbiter;
  import mult_arb_pkg::*;

  localparam int TIMEOUT = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [MAT_W-1:0] path_mat_A, path_mat_B;
  logic path_mult_en, path_rst;
  logic [RES_W-1:0] path_mat_out = '0;
  logic path_finish = 1'b0;

  int tests = 0;
  int fails = 0;
  int path_lat = 10;
  int pcnt = 0;

  always #5 clk = ~clk;

  mult_arbiter_if bus ();

  mult_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .path_mat_A   (path_mat_A),
    .path_mat_B   (path_mat_B),
    .path_mult_en (path_mult_en),
    .path_rst     (path_rst),
    .path_mat_out (path_mat_out),
    .path_finish  (path_finish)
  );

  // Plain 4x4 matrix product, element (i,j) at bits [159-10*(4i+j) -: 10].
  function automatic logic [RES_W-1:0] matmul(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    logic [RES_W-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s += int'(a[63-4*(i*4+k) -: 4]) * int'(b[63-4*(k*4+j) -: 4]);
        r[159-10*(i*4+j) -: 10] = 10'(s);
      end
    end
    return r;
  endfunction

  // Multiply path model: finish rises in the path_lat-th cycle after the strobe.
  always @(posedge clk) begin
    if (path_rst) begin
      path_finish <= 1'b0;
      pcnt <= 0;
    end else if (path_mult_en) begin
      path_mat_out <= matmul(path_mat_A, path_mat_B);
      if (path_lat <= 1) path_finish <= 1'b1;
      else pcnt <= path_lat - 1;
    end else if (pcnt != 0) begin
      pcnt <= pcnt - 1;
      if (pcnt == 1) path_finish <= 1'b1;
    end
  end

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_vec(input string name, input logic [RES_W-1:0] got, input logic [RES_W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_single(input int idx, input int port, input logic [MAT_W-1:0] a,
                            input logic [MAT_W-1:0] b, input int lat, input logic want_err,
                            input logic [RES_W-1:0] want_res, input int want_n, input bit scramble);
    int n;
    bit seen;
    @(negedge clk);
    path_lat = lat;
    if (port == 0) begin bus.mat_A0 = a; bus.mat_B0 = b; bus.req0 = 1'b1; end
    else begin bus.mat_A1 = a; bus.mat_B1 = b; bus.req1 = 1'b1; end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (scramble && n == 4) begin
        if (port == 0) begin bus.mat_A0 = {$urandom, $urandom}; bus.mat_B0 = {$urandom, $urandom}; end
        else begin bus.mat_A1 = {$urandom, $urandom}; bus.mat_B1 = {$urandom, $urandom}; end
      end
      if (bus.done0 || bus.done1) seen = 1'b1;
    end
    check_int($sformatf("v%0d_latency", idx), n, want_n);
    check_int($sformatf("v%0d_done0", idx), int'(bus.done0), (port == 0) ? 1 : 0);
    check_int($sformatf("v%0d_done1", idx), int'(bus.done1), (port == 1) ? 1 : 0);
    check_int($sformatf("v%0d_err", idx), int'(bus.err), int'(want_err));
    check_vec($sformatf("v%0d_result", idx), bus.result, want_res);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    check_int($sformatf("v%0d_busy_after", idx), int'(bus.busy), 0);
    check_int($sformatf("v%0d_path_rst_after", idx), int'(path_rst), 1);
  endtask

  typedef struct {
    int               port;
    logic [MAT_W-1:0] a;
    logic [MAT_W-1:0] b;
    int               lat;
    logic             want_err;
    logic [RES_W-1:0] want_res;
    int               want_n;
    bit               scramble;
  } vec_t;

  vec_t vecs[8];

  // Watchdog: every loop is bounded, this only guards against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RES_W-1:0] prev;
    logic [RES_W-1:0] rep4, rep900;
    int dc[$];
    int dp[$];
    int both;
    // random-run model state
    int cyc, idle_at, last, job_port, job_done_cyc, lat, jobs;
    bit job_active, job_err, want_done;
    bit pend[2];
    logic [MAT_W-1:0] opa[2];
    logic [MAT_W-1:0] opb[2];
    logic [RES_W-1:0] job_res, model_res;

    rep4   = {16{10'd4}};
    rep900 = {16{10'd900}};

    vecs[0] = '{0, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 10, 1'b0, rep4, 12, 1'b0};
    vecs[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 10, 1'b0, rep900, 12, 1'b0};
    vecs[2] = '{1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 10, 1'b0,
                matmul(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210), 12, 1'b0};
    prev = vecs[2].want_res;
    vecs[3] = '{1, 64'h2222_3333_4444_5555, 64'h3333_2222_1111_0000, 100, 1'b1, prev, TIMEOUT + 2, 1'b0};
    vecs[4] = '{0, 64'h1000_0100_0010_0001, 64'h0123_4567_89AB_CDEF, TIMEOUT, 1'b0,
                {10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7,
                 10'd8, 10'd9, 10'd10, 10'd11, 10'd12, 10'd13, 10'd14, 10'd15}, TIMEOUT + 2, 1'b0};
    vecs[5] = '{1, 64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5, 1, 1'b0,
                matmul(64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5), 3, 1'b0};
    prev = vecs[5].want_res;
    vecs[6] = '{0, 64'h7777_7777_7777_7777, 64'h9999_9999_9999_9999, TIMEOUT + 1, 1'b1, prev, TIMEOUT + 2, 1'b0};
    vecs[7] = '{0, 64'hDEAD_BEEF_0BAD_F00D, 64'hC0FF_EE12_3456_789A, 10, 1'b0,
                matmul(64'hDEAD_BEEF_0BAD_F00D, 64'hC0FF_EE12_3456_789A), 12, 1'b1};

    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.mat_A0 = '0; bus.mat_B0 = '0; bus.mat_A1 = '0; bus.mat_B1 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("rst_done0", int'(bus.done0), 0);
    check_int("rst_done1", int'(bus.done1), 0);
    check_int("rst_err", int'(bus.err), 0);
    check_int("rst_busy", int'(bus.busy), 0);
    check_int("rst_mult_en", int'(path_mult_en), 0);
    check_int("rst_path_rst", int'(path_rst), 1);
    check_vec("rst_result", bus.result, '0);
    check_vec("rst_mat_A", {96'd0, path_mat_A}, '0);
    check_vec("rst_mat_B", {96'd0, path_mat_B}, '0);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++)
      run_single(i, vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].lat,
                 vecs[i].want_err, vecs[i].want_res, vecs[i].want_n, vecs[i].scramble);

    // Reset pulled low in the middle of WAIT
    @(negedge clk);
    path_lat = 10;
    bus.mat_A0 = 64'h1111_1111_1111_1111;
    bus.mat_B0 = 64'h2222_2222_2222_2222;
    bus.req0 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_int("midrst_busy_before", int'(bus.busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_int("midrst_busy", int'(bus.busy), 0);
    check_int("midrst_path_rst", int'(path_rst), 1);
    check_int("midrst_mult_en", int'(path_mult_en), 0);
    check_int("midrst_done0", int'(bus.done0), 0);
    check_int("midrst_err", int'(bus.err), 0);
    check_vec("midrst_result", bus.result, '0);
    check_vec("midrst_mat_A", {96'd0, path_mat_A}, '0);
    bus.req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_single(8, 0, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 10, 1'b0, rep4, 12, 1'b0);

    // Both requesters raised together and held: expect 0,1,0,1,0 every 13 cycles.
    // Requests drop during the fifth job, which must still complete.
    pulse_reset();
    @(negedge clk);
    path_lat = 10;
    bus.mat_A0 = 64'h1234_5678_9ABC_DEF0; bus.mat_B0 = 64'h0FED_CBA9_8765_4321;
    bus.mat_A1 = 64'h3333_4444_5555_6666; bus.mat_B1 = 64'h7777_8888_9999_AAAA;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    both = 0;
    for (int n = 1; n <= 75; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done0 && bus.done1) both++;
      if (bus.done0 || bus.done1) begin
        dc.push_back(n);
        dp.push_back(bus.done1 ? 1 : 0);
        if (bus.done1) check_vec("rr_result1", bus.result, matmul(64'h3333_4444_5555_6666, 64'h7777_8888_9999_AAAA));
        else check_vec("rr_result0", bus.result, matmul(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321));
      end
      if (n == 55) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
    end
    check_int("rr_both_done", both, 0);
    check_int("rr_done_count", dc.size(), 5);
    for (int i = 0; i < dc.size() && i < 5; i++) begin
      check_int($sformatf("rr_port%0d", i), dp[i], i % 2);
      check_int($sformatf("rr_cycle%0d", i), dc[i], 12 + 13 * i);
    end

    // Randomized run against a transaction-level model
    pulse_reset();
    cyc = 0; idle_at = 0; last = 1; jobs = 0;
    job_active = 1'b0; job_err = 1'b0; job_port = 0; job_done_cyc = 0;
    model_res = '0; job_res = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int step = 0; step < 1200; step++) begin
      @(negedge clk);
      cyc++;
      want_done = job_active && (cyc == job_done_cyc);
      check_int("rnd_busy", int'(bus.busy), int'(job_active));
      check_int("rnd_done0", int'(bus.done0), int'(want_done && job_port == 0));
      check_int("rnd_done1", int'(bus.done1), int'(want_done && job_port == 1));
      check_int("rnd_err", int'(bus.err), int'(want_done && job_err));
      if (want_done) begin
        if (!job_err) model_res = job_res;
        check_vec("rnd_result", bus.result, model_res);
        if (job_port == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        pend[job_port] = 1'b0;
        job_active = 1'b0;
        jobs++;
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 3) == 0) begin
          opa[p] = {$urandom, $urandom};
          opb[p] = {$urandom, $urandom};
          if (p == 0) begin bus.mat_A0 = opa[p]; bus.mat_B0 = opb[p]; bus.req0 = 1'b1; end
          else begin bus.mat_A1 = opa[p]; bus.mat_B1 = opb[p]; bus.req1 = 1'b1; end
          pend[p] = 1'b1;
        end
      end
      // Operands of a job already granted may change freely.
      if (job_active && $urandom_range(0, 5) == 0) begin
        if (job_port == 0) bus.mat_A0 = {$urandom, $urandom};
        else bus.mat_B1 = {$urandom, $urandom};
      end
      if (!job_active && cyc >= idle_at && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) job_port = 1 - last;
        else job_port = pend[1] ? 1 : 0;
        last = job_port;
        lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TIMEOUT + 3)) : 10;
        path_lat = lat;
        job_err = (lat > TIMEOUT);
        job_done_cyc = cyc + 2 + (job_err ? TIMEOUT : lat);
        job_res = matmul(opa[job_port], opb[job_port]);
        job_active = 1'b1;
        idle_at = job_done_cyc + 1;
      end
    end
    check_int("rnd_enough_jobs", int'(jobs >= 30), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
